pmic_seq_datapath: RTL and testbench

//  - Datapath for the PMIC-substitute glitch sequencer; the external FSM supplies all control.
//  - Holds the 8-bit parcel-depth up/down/clear counter and forms instr_pt = parcel_start_pt + depth.
//  - Decodes the 12-bit instruction and delay table held in program ROM.
//  - Steers main/priv I2C bytes and their ready flags onto one bus.

---
 rtl/pmic_seq_datapath_if.sv | 42 ++++
 rtl/pmic_seq_datapath.sv | 79 +++++++
 tb/tb_pmic_seq_datapath.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/pmic_seq_datapath_if.sv
// Signal bundle between the glitch-sequencer FSM (master) and the PMIC sequencer datapath (slave).
// Carries the depth-counter controls, ROM/delay decode outputs and I2C bus steering.
interface pmic_seq_datapath_if #(
  parameter int DEPTH_W = 8,
  parameter int BUS_W   = 9,
  parameter int DELAY_W = 32
);
  logic               depth_inc;
  logic               depth_dec;
  logic               depth_clr;
  logic [DEPTH_W-1:0] clr_value;
  logic [DEPTH_W-1:0] parcel_start_pt;
  logic [7:0]         delay_num;
  logic [BUS_W-1:0]   i2c_main;
  logic [BUS_W-1:0]   i2c_priv;
  logic               main_ready;
  logic               priv_ready;
  logic               bus_sel;

  logic [DEPTH_W-1:0] parcel_depth;
  logic [DEPTH_W-1:0] instr_pt;
  logic [11:0]        next_instr;
  logic               dac_next;
  logic               delay_next;
  logic [DELAY_W-1:0] delay_ref;
  logic [BUS_W-1:0]   curr_i2c_bus;
  logic               i2c_ready;

  modport master (
    output depth_inc, depth_dec, depth_clr, clr_value, parcel_start_pt, delay_num,
           i2c_main, i2c_priv, main_ready, priv_ready, bus_sel,
    input  parcel_depth, instr_pt, next_instr, dac_next, delay_next, delay_ref,
           curr_i2c_bus, i2c_ready
  );

  modport slave (
    input  depth_inc, depth_dec, depth_clr, clr_value, parcel_start_pt, delay_num,
           i2c_main, i2c_priv, main_ready, priv_ready, bus_sel,
    output parcel_depth, instr_pt, next_instr, dac_next, delay_next, delay_ref,
           curr_i2c_bus, i2c_ready
  );
endinterface

// File: rtl/pmic_seq_datapath.sv
// Datapath for the PMIC-substitute glitch sequencer: parcel-depth counter, program ROM and
// delay-table decode, main/priv I2C steering. Define PMIC_DEPTH_SAT_EN for a saturating counter.
module pmic_seq_datapath #(
  parameter int DEPTH_W = 8,
  parameter int BUS_W   = 9,
  parameter int DELAY_W = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  pmic_seq_datapath_if.slave   bus
);

  logic [DEPTH_W-1:0] r_parcel_depth;
  logic [DEPTH_W-1:0] w_depth_nxt;
  logic [DEPTH_W-1:0] w_instr_pt;
  logic [11:0]        w_next_instr;
  logic [DELAY_W-1:0] w_delay_ref;

  // Program ROM: 256 x 12, format {delay, dac, bus_sel, data[8:0]}.
  function automatic logic [11:0] rom_rd(input logic [7:0] addr);
    case (addr)
      8'h00:   rom_rd = 12'h120;
      8'h01:   rom_rd = 12'h4FE;
      8'h02:   rom_rd = 12'h802;
      8'h03:   rom_rd = 12'h400;
      default: rom_rd = 12'h000;
    endcase
  endfunction

  function automatic logic [DELAY_W-1:0] delay_rd(input logic [7:0] idx);
    case (idx)
      8'd1:    delay_rd = DELAY_W'(1000);
      8'd2:    delay_rd = DELAY_W'(50000);
      default: delay_rd = '0;
    endcase
  endfunction

  // Clear beats everything; inc and dec together cancel out.
  always_comb begin
    // NOTE: default assignment first so no path leaves w_depth_nxt unassigned (no latch).
    w_depth_nxt = r_parcel_depth;
    if (bus.depth_clr) begin
      w_depth_nxt = bus.clr_value;
    end else if (bus.depth_inc && !bus.depth_dec) begin
`ifdef PMIC_DEPTH_SAT_EN
      if (r_parcel_depth != '1) w_depth_nxt = r_parcel_depth + DEPTH_W'(1);
`else
      w_depth_nxt = r_parcel_depth + DEPTH_W'(1);
`endif
    end else if (bus.depth_dec && !bus.depth_inc) begin
`ifdef PMIC_DEPTH_SAT_EN
      if (r_parcel_depth != '0) w_depth_nxt = r_parcel_depth - DEPTH_W'(1);
`else
      w_depth_nxt = r_parcel_depth - DEPTH_W'(1);
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: non-blocking assignment for all clocked state.
    if (!reset_n) r_parcel_depth <= '0;
    else          r_parcel_depth <= w_depth_nxt;
  end

  // Carry out of the address sum is dropped: the ROM address space wraps.
  assign w_instr_pt   = bus.parcel_start_pt + r_parcel_depth;
  assign w_next_instr = rom_rd(8'(w_instr_pt));
  assign w_delay_ref  = delay_rd(bus.delay_num);

  assign bus.parcel_depth = r_parcel_depth;
  assign bus.instr_pt     = w_instr_pt;
  assign bus.next_instr   = w_next_instr;
  assign bus.dac_next     = w_next_instr[10];
  assign bus.delay_next   = w_next_instr[11];
  assign bus.delay_ref    = w_delay_ref;
  assign bus.curr_i2c_bus = bus.bus_sel ? bus.i2c_priv   : bus.i2c_main;
  assign bus.i2c_ready    = bus.bus_sel ? bus.priv_ready : bus.main_ready;

endmodule

// File: tb/tb_pmic_seq_datapath.sv
// Self-checking bench for pmic_seq_datapath: a behavioural depth/ROM/table model checked every
// cycle, plus directed vectors with hand-computed literal expectations.
module tb_pmic_seq_datapath;
  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pmic_seq_datapath_if #(.DEPTH_W(8), .BUS_W(9), .DELAY_W(32)) u_if ();

  pmic_seq_datapath #(.DEPTH_W(8), .BUS_W(9), .DELAY_W(32)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (u_if)
  );

  // ---------------- behavioural model ----------------
  int model_depth = 0;
  int model_rom   [256];
  int model_delay [256];

  initial begin
    foreach (model_rom[k])   model_rom[k]   = 0;
    foreach (model_delay[k]) model_delay[k] = 0;
    model_rom[0] = 'h120; model_rom[1] = 'h4FE; model_rom[2] = 'h802; model_rom[3] = 'h400;
    model_delay[1] = 1000; model_delay[2] = 50000;
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      model_depth = 0;
    end else if (u_if.depth_clr) begin
      model_depth = int'(u_if.clr_value);
    end else if (u_if.depth_inc && !u_if.depth_dec) begin
`ifdef PMIC_DEPTH_SAT_EN
      if (model_depth < 255) model_depth = model_depth + 1;
`else
      model_depth = (model_depth + 1) % 256;
`endif
    end else if (u_if.depth_dec && !u_if.depth_inc) begin
`ifdef PMIC_DEPTH_SAT_EN
      if (model_depth > 0) model_depth = model_depth - 1;
`else
      model_depth = (model_depth + 255) % 256;
`endif
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Continuous compare on the falling edge, away from the active edge.
  always @(negedge clk) begin
    int pt;
    int ins;
    pt  = (int'(u_if.parcel_start_pt) + model_depth) % 256;
    ins = model_rom[pt];
    check("mdl_depth",    32'(u_if.parcel_depth), 32'(model_depth));
    check("mdl_instr_pt", 32'(u_if.instr_pt),     32'(pt));
    check("mdl_instr",    32'(u_if.next_instr),   32'(ins));
    check("mdl_dac",      32'(u_if.dac_next),     32'((ins >> 10) & 1));
    check("mdl_delay",    32'(u_if.delay_next),   32'((ins >> 11) & 1));
    check("mdl_dref",     u_if.delay_ref,         32'(model_delay[u_if.delay_num]));
    check("mdl_bus",      32'(u_if.curr_i2c_bus),
          32'(u_if.bus_sel ? u_if.i2c_priv : u_if.i2c_main));
    check("mdl_ready",    32'(u_if.i2c_ready),
          32'(u_if.bus_sel ? u_if.priv_ready : u_if.main_ready));
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    u_if.depth_clr = 1'b1;
    u_if.clr_value = v;
    step();
    u_if.depth_clr = 1'b0;
  endtask

  logic [11:0] exp_instr [4];
  logic        exp_dac   [4];
  logic        exp_dly   [4];

  initial begin
    exp_instr = '{12'h120, 12'h4FE, 12'h802, 12'h400};
    exp_dac   = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_dly   = '{1'b0, 1'b0, 1'b1, 1'b0};

    reset_n              = 1'b0;
    u_if.depth_inc       = 1'b0;
    u_if.depth_dec       = 1'b0;
    u_if.depth_clr       = 1'b0;
    u_if.clr_value       = 8'h00;
    u_if.parcel_start_pt = 8'h00;
    u_if.delay_num       = 8'h00;
    u_if.i2c_main        = 9'h000;
    u_if.i2c_priv        = 9'h000;
    u_if.main_ready      = 1'b0;
    u_if.priv_ready      = 1'b0;
    u_if.bus_sel         = 1'b0;
    step(); step();
    check("reset_depth", 32'(u_if.parcel_depth), 32'h00);
    reset_n = 1'b1;
    step();

    // Asynchronous reset mid-count, no clock edge in between.
    load(8'h05);
    check("pre_reset_depth", 32'(u_if.parcel_depth), 32'h05);
    #2 reset_n = 1'b0;
    #1 check("async_reset", 32'(u_if.parcel_depth), 32'h00);
    step();
    reset_n = 1'b1;
    step();

    // Counter priority.
    load(8'h10);
    u_if.depth_inc = 1'b1;
    repeat (3) step();
    u_if.depth_inc = 1'b0;
    check("inc_x3", 32'(u_if.parcel_depth), 32'h13);
    u_if.depth_inc = 1'b1; u_if.depth_dec = 1'b1;
    step();
    u_if.depth_inc = 1'b0; u_if.depth_dec = 1'b0;
    check("inc_dec_hold", 32'(u_if.parcel_depth), 32'h13);
    u_if.depth_inc = 1'b1;
    load(8'h07);
    u_if.depth_inc = 1'b0;
    check("clr_over_inc", 32'(u_if.parcel_depth), 32'h07);
    u_if.depth_dec = 1'b1;
    step();
    u_if.depth_dec = 1'b0;
    check("dec", 32'(u_if.parcel_depth), 32'h06);

    // Boundaries.
    load(8'h00);
    u_if.depth_dec = 1'b1;
    step();
    u_if.depth_dec = 1'b0;
`ifdef PMIC_DEPTH_SAT_EN
    check("dec_at_00", 32'(u_if.parcel_depth), 32'h00);
`else
    check("dec_at_00", 32'(u_if.parcel_depth), 32'hFF);
`endif
    load(8'hFF);
    u_if.depth_inc = 1'b1;
    step();
    u_if.depth_inc = 1'b0;
`ifdef PMIC_DEPTH_SAT_EN
    check("inc_at_ff", 32'(u_if.parcel_depth), 32'hFF);
`else
    check("inc_at_ff", 32'(u_if.parcel_depth), 32'h00);
`endif

    // ROM decode walk.
    u_if.parcel_start_pt = 8'h00;
    load(8'h00);
    for (int i = 0; i < 4; i++) begin
      check("rom_instr", 32'(u_if.next_instr), 32'(exp_instr[i]));
      check("rom_dac",   32'(u_if.dac_next),   32'(exp_dac[i]));
      check("rom_delay", 32'(u_if.delay_next), 32'(exp_dly[i]));
      u_if.depth_inc = 1'b1;
      step();
      u_if.depth_inc = 1'b0;
    end
    check("rom_unlisted", 32'(u_if.next_instr), 32'h000);
    u_if.parcel_start_pt = 8'hFE;
    load(8'h03);
    check("pt_wrap",       32'(u_if.instr_pt),   32'h01);
    check("pt_wrap_instr", 32'(u_if.next_instr), 32'h4FE);
    u_if.parcel_start_pt = 8'hF0;
    load(8'h20);
    check("pt_carry", 32'(u_if.instr_pt), 32'h10);

    // Delay table and bus mux (combinational).
    u_if.delay_num = 8'd1;
    #1 check("delay_1", u_if.delay_ref, 32'd1000);
    u_if.delay_num = 8'd2;
    #1 check("delay_2", u_if.delay_ref, 32'd50000);
    u_if.delay_num = 8'd9;
    #1 check("delay_9", u_if.delay_ref, 32'd0);
    u_if.i2c_main = 9'h120; u_if.main_ready = 1'b1;
    u_if.i2c_priv = 9'h0A1; u_if.priv_ready = 1'b0;
    u_if.bus_sel  = 1'b0;
    #1 check("mux_main",       32'(u_if.curr_i2c_bus), 32'h120);
    check("mux_main_ready",    32'(u_if.i2c_ready),    32'h1);
    u_if.bus_sel = 1'b1;
    #1 check("mux_priv",       32'(u_if.curr_i2c_bus), 32'h0A1);
    check("mux_priv_ready",    32'(u_if.i2c_ready),    32'h0);
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
